// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_inst_fifo.sv
// In-order buffer of {pc, instruction} pairs between the memory response path and the decoder.
// A flush empties the buffer and wins over a push or pop in the same cycle.
module inst_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [XLEN-1:0]          push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     valid,
    output logic [XLEN-1:0]          head_pc,
    output logic [XLEN-1:0]          head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Qualify push/pop against flush and occupancy.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_push_s = push && (count_r != CW'(DEPTH));
            do_pop_s  = pop && (count_r != CW'(0));
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            pc_mem_r[wr_ptr_r]   <= push_pc;
            data_mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head presentation; stale storage is masked to zero while empty.
    always_comb begin
        valid     = (count_r != CW'(0));
        count     = count_r;
        head_pc   = {XLEN{1'b0}};
        head_data = {XLEN{1'b0}};
        if (valid) begin
            head_pc   = pc_mem_r[rd_ptr_r];
            head_data = data_mem_r[rd_ptr_r];
        end else begin
            head_pc   = {XLEN{1'b0}};
            head_data = {XLEN{1'b0}};
        end
    end

endmodule : inst_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited memory requests,
// in-order response buffering and redirect handling with flush of stale responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

    fetch_state_e    state_r;
    fetch_state_e    state_next_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] fetch_pc_next_s;
    logic [XLEN-1:0] rsp_pc_r;
    logic [XLEN-1:0] rsp_pc_next_s;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   outstanding_next_s;
    logic [CW-1:0]   fifo_count_s;
    logic            credit_ok_s;
    logic            req_fire_s;
    logic            rsp_take_s;
    logic            push_s;
    logic            pop_s;
    logic [XLEN-1:0] redirect_pc_s;

    // Request channel: credits cover both in-flight requests and buffered entries,
    // so every response is guaranteed a free buffer slot.
    always_comb begin
        credit_ok_s    = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < (CW + 1)'(DEPTH);
        imem_req_valid = 1'b0;
        if (!rst && (state_r == FETCH_RUN) && !redirect_valid) begin
            imem_req_valid = credit_ok_s;
        end else begin
            imem_req_valid = 1'b0;
        end
        imem_req_addr = fetch_pc_r;
        req_fire_s    = imem_req_valid && imem_req_ready;
        rsp_take_s    = imem_rsp_valid && (outstanding_r != CW'(0));
        push_s        = rsp_take_s && (state_r == FETCH_RUN) && !redirect_valid;
        pop_s         = inst_valid && inst_ready;
        redirect_pc_s = redirect_pc & ALIGN_MASK;
    end

    // Next-state, PC and outstanding-count logic; redirect overrides everything else.
    always_comb begin
        state_next_s       = state_r;
        fetch_pc_next_s    = fetch_pc_r;
        rsp_pc_next_s      = rsp_pc_r;
        outstanding_next_s = outstanding_r + CW'(req_fire_s) - CW'(rsp_take_s);
        if (redirect_valid) begin
            fetch_pc_next_s = redirect_pc_s;
            rsp_pc_next_s   = redirect_pc_s;
            if (outstanding_next_s != CW'(0)) begin
                state_next_s = FETCH_FLUSH;
            end else begin
                state_next_s = FETCH_RUN;
            end
        end else begin
            case (state_r)
                FETCH_RUN: begin
                    state_next_s = FETCH_RUN;
                    if (req_fire_s) begin
                        fetch_pc_next_s = fetch_pc_r + PC_STEP;
                    end else begin
                        fetch_pc_next_s = fetch_pc_r;
                    end
                    if (push_s) begin
                        rsp_pc_next_s = rsp_pc_r + PC_STEP;
                    end else begin
                        rsp_pc_next_s = rsp_pc_r;
                    end
                end
                FETCH_FLUSH: begin
                    if (outstanding_next_s == CW'(0)) begin
                        state_next_s = FETCH_RUN;
                    end else begin
                        state_next_s = FETCH_FLUSH;
                    end
                end
                default: begin
                    state_next_s = FETCH_RUN;
                end
            endcase
        end
    end

    // State, PC and credit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= FETCH_RUN;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= CW'(0);
        end else begin
            state_r       <= state_next_s;
            fetch_pc_r    <= fetch_pc_next_s;
            rsp_pc_r      <= rsp_pc_next_s;
            outstanding_r <= outstanding_next_s;
        end
    end

    inst_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_pc   (rsp_pc_r),
        .push_data (imem_rsp_data),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .valid     (inst_valid),
        .head_pc   (inst_pc),
        .head_data (inst_data),
        .count     (fifo_count_s)
    );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a fixed-latency instruction memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          accepted = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request handshake, advance, then drive this cycle's response.
    task automatic tick();
        logic        fire;
        logic [31:0] addr;
        #1;
        fire = imem_req_valid && imem_req_ready;
        addr = imem_req_addr;
        if (fire) accepted++;
        @(posedge clk);
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end else if (fire) begin
            q_addr.push_back(addr);
            q_due.push_back(cyc + lat);
        end
        cyc++;
        @(negedge clk);
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_state", 32'(dut.state_r), 32'(FETCH_RUN));
        chk("rst_outstanding", 32'(dut.outstanding_r), 32'h0);
        chk("rst_count", 32'(dut.fifo_count_s), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
        chk("post_rst_req_addr", imem_req_addr, 32'h0);
        accepted = 0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_wrap [4];
        int          n;
        bit          seen;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Streaming with a 1-cycle memory and an always-ready decoder.
        lat        = 1;
        inst_ready = 1'b1;
        do_reset();
        tick();
        chk("stream_no_bypass", 32'(inst_valid), 32'h0);
        chk("stream_req_addr1", imem_req_addr, 32'h4);
        tick();
        chk("stream_first_valid", 32'(inst_valid), 32'h1);
        chk("stream_first_pc", inst_pc, 32'h0);
        chk("stream_first_data", inst_data, mem_word(32'h0));
        exp_pc = 32'h4;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stream_valid", 32'(inst_valid), 32'h1);
            chk("stream_pc", inst_pc, exp_pc);
            chk("stream_data", inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'h4;
        end

        // Decoder stalled: credits limit issue to DEPTH requests.
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("full_accepted", 32'(accepted), 32'd4);
        chk("full_req_valid", 32'(imem_req_valid), 32'h0);
        chk("full_count", 32'(dut.fifo_count_s), 32'd4);
        inst_ready = 1'b1;
        exp_pc     = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("full_valid", 32'(inst_valid), 32'h1);
            chk("full_pc", inst_pc, exp_pc);
            chk("full_data", inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'h4;
            tick();
        end

        // Redirect with two requests outstanding on a 3-cycle memory.
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        chk("redir_req_drop", 32'(imem_req_valid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("flush_state1", 32'(dut.state_r), 32'(FETCH_FLUSH));
        chk("flush_req_valid1", 32'(imem_req_valid), 32'h0);
        tick();
        chk("flush_state2", 32'(dut.state_r), 32'(FETCH_FLUSH));
        chk("flush_empty", 32'(inst_valid), 32'h0);
        tick();
        chk("flush_done_state", 32'(dut.state_r), 32'(FETCH_RUN));
        chk("flush_done_req_valid", 32'(imem_req_valid), 32'h1);
        chk("flush_done_req_addr", imem_req_addr, 32'h0000_0100);
        chk("flush_done_empty", 32'(inst_valid), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = inst_valid;
        end
        chk("redir_inst_seen", 32'(seen), 32'h1);
        chk("redir_inst_pc", inst_pc, 32'h0000_0100);
        chk("redir_inst_data", inst_data, mem_word(32'h0000_0100));

        // Redirect coinciding with a response; low PC bits ignored.
        lat        = 1;
        inst_ready = 1'b0;
        do_reset();
        tick();
        chk("coinc_rsp_present", 32'(imem_rsp_valid), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        chk("coinc_req_drop", 32'(imem_req_valid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("coinc_discarded", 32'(inst_valid), 32'h0);
        chk("coinc_state", 32'(dut.state_r), 32'(FETCH_RUN));
        chk("coinc_req_valid", 32'(imem_req_valid), 32'h1);
        chk("coinc_req_addr", imem_req_addr, 32'h0000_0200);

        // PC wrap across the top of the address space.
        inst_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_req_valid", 32'(imem_req_valid), 32'h1);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        exp_wrap[0] = 32'hFFFF_FFF8;
        exp_wrap[1] = 32'hFFFF_FFFC;
        exp_wrap[2] = 32'h0000_0000;
        exp_wrap[3] = 32'h0000_0004;
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            tick();
            if (inst_valid) begin
                chk("wrap_pc", inst_pc, exp_wrap[n]);
                chk("wrap_data", inst_data, mem_word(exp_wrap[n]));
                n++;
            end
        end
        chk("wrap_count", 32'(n), 32'd4);

        // Reset in the middle of a flush.
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("midrst_flush_state", 32'(dut.state_r), 32'(FETCH_FLUSH));
        rst = 1'b1;
        tick();
        chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("midrst_inst_valid", 32'(inst_valid), 32'h0);
        chk("midrst_inst_data", inst_data, 32'h0);
        chk("midrst_inst_pc", inst_pc, 32'h0);
        chk("midrst_state", 32'(dut.state_r), 32'(FETCH_RUN));
        chk("midrst_outstanding", 32'(dut.outstanding_r), 32'h0);
        rst = 1'b0;
        #1;
        chk("midrst_req_valid_after", 32'(imem_req_valid), 32'h1);
        chk("midrst_req_addr_after", imem_req_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
